// File: rtl/mvm_pkg.sv
// Shared types and helpers for the streaming matrix-vector multiplier.
package mvm_pkg;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_A,
      LOAD_X,
      COMPUTE,
      OUTPUT
   } mvm_state_e;

   // Working width for narrow(); every accumulator is sign-extended to this.
   localparam int unsigned NARROW_W = 64;

   // Accumulator width that holds COLS full-width products without overflow.
   function automatic int unsigned acc_width(input int unsigned in_w,
                                             input int unsigned cols);
      return 2 * in_w + $clog2(cols);
   endfunction

   // Narrow a sign-extended accumulator to out_w bits: wrap or clamp.
   // The result is sign-extended back to NARROW_W so callers can compare it
   // with the input to detect clamping.
   function automatic logic signed [NARROW_W-1:0] narrow(
      input logic signed [NARROW_W-1:0] acc,
      input int unsigned                out_w,
      input bit                         sat);
      logic signed [NARROW_W-1:0] hi;
      logic signed [NARROW_W-1:0] lo;
      logic signed [NARROW_W-1:0] wrapped;
      hi      = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo      = -hi - 64'sd1;
      wrapped = (acc <<< (NARROW_W - out_w)) >>> (NARROW_W - out_w);
      if (sat) begin
         if (acc > hi) return hi;
         if (acc < lo) return lo;
         return acc;
      end
      return wrapped;
   endfunction

endpackage

// File: rtl/mvm_mac.sv
// Signed multiply-accumulate; the first term of a dot product discards the
// previous sum. sum_o is the combinational result of the current step.
module mvm_mac
   import mvm_pkg::*;
#(
   parameter int INPUT_WIDTH = 8,
   parameter int ACC_W       = 18
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          en_i,
   input  logic                          first_i,
   input  logic signed [INPUT_WIDTH-1:0] a_i,
   input  logic signed [INPUT_WIDTH-1:0] b_i,
   output logic signed [ACC_W-1:0]       sum_o
);

   logic signed [2*INPUT_WIDTH-1:0] prod;
   logic signed [ACC_W-1:0]         base;
   logic signed [ACC_W-1:0]         acc_q;
   logic signed [ACC_W-1:0]         acc_d;

   // Product plus either zero (first term) or the running sum.
   always_comb begin
      prod  = a_i * b_i;
      base  = first_i ? '0 : acc_q;
      sum_o = base + ACC_W'(prod);
      acc_d = en_i ? sum_o : acc_q;
   end

   // Running-sum register.
   always_ff @(posedge clk) begin
      if (reset) acc_q <= '0;
      else       acc_q <= acc_d;
   end

endmodule

// File: rtl/mvm_stream.sv
// Streaming signed matrix-vector multiplier y = A*x with valid/ready I/O.
// A is loaded row-major, then x; rows of y are streamed out row 0 first.
// Optional: define MVM_STREAM_SAT_EN for saturating narrowing plus sat_flag.
module mvm_stream
   import mvm_pkg::*;
#(
   parameter int ROWS         = 4,
   parameter int COLS         = 4,
   parameter int INPUT_WIDTH  = 8,
   parameter int OUTPUT_WIDTH = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           start,
   input  logic                           keep_matrix,
   input  logic                           in_valid,
   output logic                           in_ready,
   input  logic signed [INPUT_WIDTH-1:0]  data_in,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic signed [OUTPUT_WIDTH-1:0] data_out,
   output logic                           out_last,
   output logic                           done
`ifdef MVM_STREAM_SAT_EN
   ,
   output logic                           sat_flag
`endif
);

   localparam int unsigned ACC_W = acc_width(INPUT_WIDTH, COLS);
   localparam int unsigned RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int unsigned CW    = $clog2(COLS);
   localparam logic [RW-1:0] R_LAST = RW'(ROWS - 1);
   localparam logic [CW-1:0] K_LAST = CW'(COLS - 1);
`ifdef MVM_STREAM_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   mvm_state_e                     state_q, state_d;
   logic [RW-1:0]                  r_q, r_d;
   logic [CW-1:0]                  k_q, k_d;
   logic                           a_loaded_q, a_loaded_d;
   logic                           out_valid_q, out_valid_d;
   logic                           out_last_q, out_last_d;
   logic                           done_q, done_d;
   logic signed [OUTPUT_WIDTH-1:0] data_out_q, data_out_d;
`ifdef MVM_STREAM_SAT_EN
   logic                           sat_q, sat_d;
`endif

   logic signed [INPUT_WIDTH-1:0]  a_mem [ROWS][COLS];
   logic signed [INPUT_WIDTH-1:0]  x_mem [COLS];

   logic                           in_xfer, out_xfer;
   logic                           mac_en, mac_first;
   logic signed [ACC_W-1:0]        mac_sum;
   logic signed [NARROW_W-1:0]     acc_wide;

   assign in_ready  = (state_q == LOAD_A) || (state_q == LOAD_X);
   assign in_xfer   = in_valid & in_ready;
   assign out_xfer  = out_valid_q & out_ready;
   assign out_valid = out_valid_q;
   assign out_last  = out_last_q;
   assign data_out  = data_out_q;
   assign done      = done_q;
`ifdef MVM_STREAM_SAT_EN
   assign sat_flag  = sat_q;
`endif

   mvm_mac #(
      .INPUT_WIDTH (INPUT_WIDTH),
      .ACC_W       (ACC_W)
   ) u_mac (
      .clk     (clk),
      .reset   (reset),
      .en_i    (mac_en),
      .first_i (mac_first),
      .a_i     (a_mem[r_q][k_q]),
      .b_i     (x_mem[k_q]),
      .sum_o   (mac_sum)
   );

   // Operand storage; r_q/k_q double as load pointers while loading.
   always_ff @(posedge clk) begin
      if (in_xfer) begin
         if (state_q == LOAD_A) a_mem[r_q][k_q] <= data_in;
         else                   x_mem[k_q]      <= data_in;
      end
   end

   // Next-state, counter and output-register logic.
   always_comb begin
      state_d     = state_q;
      r_d         = r_q;
      k_d         = k_q;
      a_loaded_d  = a_loaded_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;
      data_out_d  = data_out_q;
      done_d      = 1'b0;
      mac_en      = 1'b0;
      mac_first   = 1'b0;
      acc_wide    = NARROW_W'(mac_sum);
`ifdef MVM_STREAM_SAT_EN
      sat_d       = sat_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               r_d     = '0;
               k_d     = '0;
               state_d = (keep_matrix && a_loaded_q) ? LOAD_X : LOAD_A;
            end
         end
         LOAD_A: begin
            if (in_xfer) begin
               if (k_q == K_LAST) begin
                  k_d = '0;
                  if (r_q == R_LAST) begin
                     r_d        = '0;
                     a_loaded_d = 1'b1;
                     state_d    = LOAD_X;
                  end else begin
                     r_d = r_q + 1'b1;
                  end
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
         end
         LOAD_X: begin
            if (in_xfer) begin
               if (k_q == K_LAST) begin
                  k_d     = '0;
                  r_d     = '0;
                  state_d = COMPUTE;
               end else begin
                  k_d = k_q + 1'b1;
               end
            end
         end
         COMPUTE: begin
            mac_en    = 1'b1;
            mac_first = (k_q == '0);
            if (k_q == K_LAST) begin
               k_d         = '0;
               data_out_d  = OUTPUT_WIDTH'(narrow(acc_wide, OUTPUT_WIDTH, SAT));
               out_valid_d = 1'b1;
               out_last_d  = (r_q == R_LAST);
`ifdef MVM_STREAM_SAT_EN
               sat_d       = (narrow(acc_wide, OUTPUT_WIDTH, 1'b1) != acc_wide);
`endif
               state_d     = OUTPUT;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         OUTPUT: begin
            if (out_xfer) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
`ifdef MVM_STREAM_SAT_EN
               sat_d       = 1'b0;
`endif
               if (r_q == R_LAST) begin
                  r_d     = '0;
                  done_d  = 1'b1;
                  state_d = IDLE;
               end else begin
                  r_d     = r_q + 1'b1;
                  state_d = COMPUTE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and control registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         r_q         <= '0;
         k_q         <= '0;
         a_loaded_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
         done_q      <= 1'b0;
         data_out_q  <= '0;
`ifdef MVM_STREAM_SAT_EN
         sat_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         r_q         <= r_d;
         k_q         <= k_d;
         a_loaded_q  <= a_loaded_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
         done_q      <= done_d;
         data_out_q  <= data_out_d;
`ifdef MVM_STREAM_SAT_EN
         sat_q       <= sat_d;
`endif
      end
   end

endmodule

// File: tb/tb_mvm_stream.sv
// Directed bench for mvm_stream: a 4x4 instance and a 2x3 instance share
// the input bus; only the started instance raises in_ready.
module tb_mvm_stream;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                reset, start_a, start_b, keep_matrix, in_valid, out_ready;
   logic signed [7:0]   data_in;
   logic                in_ready_a, out_valid_a, out_last_a, done_a;
   logic signed [15:0]  data_out_a;
   logic                in_ready_b, out_valid_b, out_last_b, done_b;
   logic signed [15:0]  data_out_b;
`ifdef MVM_STREAM_SAT_EN
   logic                sat_a, sat_b;
   localparam longint   OVF_Y = 32767;
`else
   localparam longint   OVF_Y = -1020;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   mvm_stream #(.ROWS(4), .COLS(4), .INPUT_WIDTH(8), .OUTPUT_WIDTH(16)) u_dut_a (
      .clk(clk), .reset(reset), .start(start_a), .keep_matrix(keep_matrix),
      .in_valid(in_valid), .in_ready(in_ready_a), .data_in(data_in),
      .out_valid(out_valid_a), .out_ready(out_ready), .data_out(data_out_a),
      .out_last(out_last_a), .done(done_a)
`ifdef MVM_STREAM_SAT_EN
      , .sat_flag(sat_a)
`endif
   );

   mvm_stream #(.ROWS(2), .COLS(3), .INPUT_WIDTH(8), .OUTPUT_WIDTH(16)) u_dut_b (
      .clk(clk), .reset(reset), .start(start_b), .keep_matrix(keep_matrix),
      .in_valid(in_valid), .in_ready(in_ready_b), .data_in(data_in),
      .out_valid(out_valid_b), .out_ready(out_ready), .data_out(data_out_b),
      .out_last(out_last_b), .done(done_b)
`ifdef MVM_STREAM_SAT_EN
      , .sat_flag(sat_b)
`endif
   );

   task automatic check_eq(input string tag, input longint obs, input longint exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic rdy(input int s);
      return (s != 0) ? in_ready_b : in_ready_a;
   endfunction
   function automatic logic ovld(input int s);
      return (s != 0) ? out_valid_b : out_valid_a;
   endfunction
   function automatic logic olast(input int s);
      return (s != 0) ? out_last_b : out_last_a;
   endfunction
   function automatic logic dn(input int s);
      return (s != 0) ? done_b : done_a;
   endfunction
   function automatic longint dout(input int s);
      return (s != 0) ? longint'(data_out_b) : longint'(data_out_a);
   endfunction
`ifdef MVM_STREAM_SAT_EN
   function automatic logic osat(input int s);
      return (s != 0) ? sat_b : sat_a;
   endfunction
`endif

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input int s, input logic keep);
      keep_matrix = keep;
      if (s != 0) start_b = 1'b1;
      else        start_a = 1'b1;
      tick();
      start_a     = 1'b0;
      start_b     = 1'b0;
      keep_matrix = 1'b0;
   endtask

   task automatic send(input int s, input int w, input bit gap);
      int n = 0;
      data_in  = 8'(w);
      in_valid = 1'b1;
      while (!rdy(s) && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) check_eq("in_ready_timeout", 0, 1);
      tick();
      in_valid = 1'b0;
      if (gap) tick();
   endtask

   task automatic get_row(input int s, input string tag, input longint exp,
                          input bit exp_last, input int exp_wait, input int stall,
                          input bit exp_sat);
      int n = 0;
      out_ready = (stall == 0);
      while (!ovld(s) && n < 100) begin
         tick();
         n++;
      end
      if (n >= 100) check_eq({tag, "_timeout"}, 0, 1);
      if (exp_wait >= 0) check_eq({tag, "_wait"}, n, exp_wait);
      check_eq({tag, "_data"}, dout(s), exp);
      check_eq({tag, "_last"}, olast(s), exp_last);
`ifdef MVM_STREAM_SAT_EN
      check_eq({tag, "_sat"}, osat(s), exp_sat);
`else
      if (exp_sat) n = n + 0;
`endif
      for (int i = 0; i < stall; i++) begin
         tick();
         check_eq({tag, "_hold_valid"}, ovld(s), 1);
         check_eq({tag, "_hold_data"}, dout(s), exp);
         check_eq({tag, "_hold_last"}, olast(s), exp_last);
      end
      out_ready = 1'b1;
      tick();
      check_eq({tag, "_cleared"}, ovld(s), 0);
   endtask

   int ga[16] = '{1, -2, 3, -4, 5, 6, 7, 8, -1, -1, -1, -1, 0, 2, 0, -3};
   int gx[4]  = '{2, 3, -1, 4};
   int gy[4]  = '{-23, 53, -8, -6};
   int rx[4]  = '{-1, 0, 5, 7};
   int na[6]  = '{1, 2, 3, -4, 5, -6};
   int nx[3]  = '{2, -1, 3};
   int ny[2]  = '{9, -31};

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; start_a = 1'b0; start_b = 1'b0; keep_matrix = 1'b0;
      in_valid = 1'b0; out_ready = 1'b0; data_in = '0;
      tick();
      tick();
      check_eq("rst_in_ready", in_ready_a, 0);
      check_eq("rst_out_valid", out_valid_a, 0);
      check_eq("rst_out_last", out_last_a, 0);
      check_eq("rst_done", done_a, 0);
      check_eq("rst_data_out", data_out_a, 0);
      check_eq("rst_b_in_ready", in_ready_b, 0);
      reset = 1'b0;
      tick();

      // identity matrix, x = 1..4
      pulse_start(0, 1'b0);
      check_eq("id_in_ready", in_ready_a, 1);
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++) send(0, (r == c) ? 1 : 0, 1'b0);
      for (int c = 0; c < 4; c++) send(0, c + 1, 1'b0);
      for (int r = 0; r < 4; r++) get_row(0, "id", r + 1, r == 3, 4, 0, 1'b0);
      check_eq("id_done", done_a, 1);

      // matrix reuse, requested in the done cycle
      pulse_start(0, 1'b1);
      check_eq("id_done_drop", done_a, 0);
      check_eq("reuse_in_ready", in_ready_a, 1);
      for (int c = 0; c < 4; c++) send(0, rx[c], 1'b0);
      check_eq("reuse_in_ready_low", in_ready_a, 0);
      for (int r = 0; r < 4; r++) get_row(0, "reuse", rx[r], r == 3, 4, 0, 1'b0);
      check_eq("reuse_done", done_a, 1);
      tick();
      check_eq("reuse_done_drop", done_a, 0);

      // input gaps and output backpressure on row 1
      pulse_start(0, 1'b0);
      for (int i = 0; i < 16; i++) send(0, ga[i], 1'b1);
      for (int i = 0; i < 4; i++) send(0, gx[i], i < 3);
      for (int r = 0; r < 4; r++) get_row(0, "bp", gy[r], r == 3, 4, (r == 1) ? 3 : 0, 1'b0);
      tick();

      // overflow: 4 * 127 * 127 = 64516
      pulse_start(0, 1'b0);
      for (int i = 0; i < 20; i++) send(0, 127, 1'b0);
      for (int r = 0; r < 4; r++) get_row(0, "ovf", OVF_Y, r == 3, 4, 0, 1'b1);
      tick();

      // start during LOAD_X is ignored
      pulse_start(0, 1'b0);
      for (int i = 0; i < 16; i++) send(0, 1, 1'b0);
      send(0, 1, 1'b0);
      send(0, 2, 1'b0);
      pulse_start(0, 1'b0);
      check_eq("ign_in_ready", in_ready_a, 1);
      send(0, 3, 1'b0);
      send(0, 4, 1'b0);
      check_eq("ign_in_ready_low", in_ready_a, 0);
      for (int r = 0; r < 4; r++) get_row(0, "ign", 10, r == 3, 4, 0, 1'b0);
      tick();

      // reset mid-COMPUTE, then keep_matrix must be ignored
      pulse_start(0, 1'b1);
      for (int i = 0; i < 4; i++) send(0, 1, 1'b0);
      tick();
      reset = 1'b1;
      tick();
      check_eq("mid_rst_in_ready", in_ready_a, 0);
      check_eq("mid_rst_out_valid", out_valid_a, 0);
      check_eq("mid_rst_out_last", out_last_a, 0);
      check_eq("mid_rst_done", done_a, 0);
      check_eq("mid_rst_data_out", data_out_a, 0);
      reset = 1'b0;
      tick();
      pulse_start(0, 1'b1);
      for (int i = 0; i < 4; i++) send(0, 2, 1'b0);
      check_eq("post_rst_loads_a", in_ready_a, 1);
      for (int i = 0; i < 12; i++) send(0, 2, 1'b0);
      for (int i = 0; i < 4; i++) send(0, 1, 1'b0);
      for (int r = 0; r < 4; r++) get_row(0, "post_rst", 8, r == 3, 4, 0, 1'b0);
      tick();

      // non-square 2x3
      pulse_start(1, 1'b0);
      for (int i = 0; i < 6; i++) send(1, na[i], 1'b0);
      for (int i = 0; i < 3; i++) send(1, nx[i], 1'b0);
      for (int r = 0; r < 2; r++) get_row(1, "ns", ny[r], r == 1, 3, 0, 1'b0);
      check_eq("ns_done", dn(1), 1);
      tick();
      check_eq("ns_done_drop", dn(1), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
